// File: rtl/fetch.sv
// fetch: instruction fetch stage, single-outstanding word reads, small
// instruction FIFO, static JMP/JAL taken prediction, execute redirect.
//
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   o_mem_req/addr      word read request, held until i_mem_ack
//   i_mem_ack/data      read completion and instruction word
//   o_instr_l, o_imm_pass, o_jmp_pred_pass, o_submit -> decode
//   i_next_ready        decode can accept
//   i_pc_ovr/_val       execute redirect and its target
module fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          I_SIZE     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_mem_req,
  output logic [15:0]       o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [I_SIZE-1:0] i_mem_data,
  output logic [15:0]       o_instr_l,
  output logic [I_SIZE-17:0] o_imm_pass,
  output logic              o_jmp_pred_pass,
  output logic              o_submit,
  input  logic              i_next_ready,
  input  logic              i_pc_ovr,
  input  logic [15:0]       i_pc_ovr_val
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = I_SIZE + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  // S_DROP: a request is in flight whose data belongs to a
  // flushed path and must be thrown away when it returns.
  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DROP
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [15:0]   addr_q, addr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_pp;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] head;

  logic          ack;
  logic          pred;
  logic          push;
  logic          pop;
  logic [15:0]   imm16;
  logic [15:0]   seq_pc;

  assign o_mem_req  = (state_q != S_IDLE);
  assign o_mem_addr = addr_q;

  assign ack   = o_mem_req && i_mem_ack;
  assign imm16 = i_mem_data[16 +: 16];

  // JMP with cond 0 and JAL are always taken.
  assign pred =
    ((i_mem_data[6:0] == 7'h0E) &&
     (i_mem_data[10:7] == 4'h0)) ||
    (i_mem_data[6:0] == 7'h0F);

  assign seq_pc = pred ? imm16 : pc_q + 16'd1;

  assign push = ack && (state_q == S_BUSY) && !i_pc_ovr;
  assign pop  = !i_pc_ovr && i_next_ready &&
                (cnt_q != '0);
  assign head = mem_q[rd_q];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    cnt_pp  = cnt_q + CW'(push) - CW'(pop);
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    if (i_pc_ovr) begin
      pc_d  = i_pc_ovr_val;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      // An unacked request cannot be withdrawn; wait it out.
      if (o_mem_req && !i_mem_ack) begin
        state_d = S_DROP;
      end else begin
        state_d = S_BUSY;
        addr_d  = i_pc_ovr_val;
      end
    end else begin
      cnt_d = cnt_pp;
      unique case (state_q)
        S_IDLE: begin
          if (cnt_q < DEPTH) begin
            state_d = S_BUSY;
            addr_d  = pc_q;
          end
        end
        S_DROP: begin
          if (i_mem_ack) begin
            state_d = S_BUSY;
            addr_d  = pc_q;
          end
        end
        S_BUSY: begin
          if (i_mem_ack) begin
            pc_d    = seq_pc;
            addr_d  = seq_pc;
            state_d = (cnt_pp < DEPTH) ?
                      S_BUSY : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= S_IDLE;
      pc_q            <= RESET_PC;
      addr_q          <= '0;
      rd_q            <= '0;
      wr_q            <= '0;
      cnt_q           <= '0;
      o_submit        <= 1'b0;
      o_instr_l       <= '0;
      o_imm_pass      <= '0;
      o_jmp_pred_pass <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      o_submit <= pop;
      if (push)
        mem_q[wr_q] <= {pred, i_mem_data};
      if (pop) begin
        o_jmp_pred_pass <= head[EW-1];
        o_imm_pass      <= head[I_SIZE-1:16];
        o_instr_l       <= head[15:0];
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: randomized bench for fetch against a transaction-level
// model (program walk + FIFO queue) with directed scenarios.
module tb_fetch;

  localparam int DEPTH = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_data = '0;
  logic [15:0] o_instr_l;
  logic [15:0] o_imm_pass;
  logic        o_jmp_pred_pass;
  logic        o_submit;
  logic        i_next_ready = 1'b0;
  logic        i_pc_ovr = 1'b0;
  logic [15:0] i_pc_ovr_val = '0;

  fetch #(
    .RESET_PC  (16'h0000),
    .FIFO_DEPTH(DEPTH),
    .I_SIZE    (32)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .o_mem_req      (o_mem_req),
    .o_mem_addr     (o_mem_addr),
    .i_mem_ack      (i_mem_ack),
    .i_mem_data     (i_mem_data),
    .o_instr_l      (o_instr_l),
    .o_imm_pass     (o_imm_pass),
    .o_jmp_pred_pass(o_jmp_pred_pass),
    .o_submit       (o_submit),
    .i_next_ready   (i_next_ready),
    .i_pc_ovr       (i_pc_ovr),
    .i_pc_ovr_val   (i_pc_ovr_val)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] word;
    logic        pred;
  } ent_t;

  ent_t        q[$];
  logic [15:0] acc_log[$];
  logic [31:0] prog [logic [15:0]];

  int          n_tests = 0;
  int          n_fail = 0;
  bit          jmp_en;
  logic [15:0] exp_pc;
  bit          drop_m;
  bit          pend;
  int          lat;
  int          lat_fix;
  int          rdy_pct;
  int          ovr_pct;
  bit          f_ovr;
  logic [15:0] f_val;
  logic [47:0] last_out;
  int          idle_run;
  int          n_ack;
  int          n_sub;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic bit is_pred(logic [31:0] w);
    return (w[6:0] == 7'h0E && w[10:7] == 4'd0) ||
           (w[6:0] == 7'h0F);
  endfunction

  function automatic logic [15:0] nxt(logic [15:0] a,
                                      logic [31:0] w);
    return is_pred(w) ? w[31:16] : a + 16'd1;
  endfunction

  // kind 0 plain, 1 JMP cond 0, 2 JAL, 3 JMP cond != 0
  function automatic logic [31:0] mk(int kind,
                                     logic [15:0] imm);
    logic [31:0] w;
    w = $urandom;
    w[31:16] = imm;
    case (kind)
      0: w[6:0] = 7'h33;
      1: begin w[6:0] = 7'h0E; w[10:7] = 4'd0; end
      2: w[6:0] = 7'h0F;
      default: begin
        w[6:0]  = 7'h0E;
        w[10:7] = 4'($urandom_range(1, 15));
      end
    endcase
    return w;
  endfunction

  function automatic logic [31:0] get_word(logic [15:0] a);
    int k;
    if (!prog.exists(a)) begin
      k = jmp_en ? $urandom_range(0, 9) : 0;
      if (k <= 6)
        prog[a] = mk(0, 16'($urandom));
      else
        prog[a] = mk(k - 6, 16'($urandom_range(0, 63)));
    end
    return prog[a];
  endfunction

  task automatic model_reset();
    q.delete();
    exp_pc   = 16'h0000;
    drop_m   = 0;
    pend     = 0;
    lat      = 0;
    last_out = '0;
    idle_run = 0;
  endtask

  task automatic step();
    logic        pre_req;
    logic [15:0] pre_addr;
    logic [15:0] oval;
    bit          ack, ovr, rdy, exp_sub;
    ent_t        e;
    rdy  = ($urandom_range(0, 99) < rdy_pct);
    ovr  = f_ovr || ($urandom_range(0, 999) < ovr_pct);
    if (f_ovr)
      oval = f_val;
    else if ($urandom_range(0, 3) == 0)
      oval = 16'($urandom_range(16'hFFF8, 16'hFFFF));
    else
      oval = 16'($urandom_range(0, 63));
    f_ovr = 0;
    i_next_ready = rdy;
    i_pc_ovr     = ovr;
    i_pc_ovr_val = oval;
    i_mem_ack    = 1'b0;
    i_mem_data   = $urandom;
    if (o_mem_req) begin
      if (!pend) begin
        pend = 1;
        lat  = (lat_fix >= 0) ? lat_fix
                              : $urandom_range(0, 3);
      end
      if (lat == 0) begin
        i_mem_ack  = 1'b1;
        i_mem_data = get_word(o_mem_addr);
      end else begin
        lat--;
      end
    end else begin
      pend = 0;
    end
    pre_req  = o_mem_req;
    pre_addr = o_mem_addr;
    ack      = pre_req && i_mem_ack;
    exp_sub  = rdy && !ovr && (q.size() > 0);

    @(posedge i_clk);
    #1;
    if (ack) pend = 0;

    check("submit", o_submit, exp_sub);
    if (exp_sub) begin
      e = q.pop_front();
      last_out = {7'd0, e.pred, e.word[31:16], e.word[15:0]};
      n_sub++;
      check("out", {o_jmp_pred_pass, o_imm_pass, o_instr_l},
            last_out);
    end else begin
      check("hold", {o_jmp_pred_pass, o_imm_pass, o_instr_l},
            last_out);
    end

    if (ovr) begin
      q.delete();
      exp_pc = oval;
      if (pre_req && !ack) begin
        drop_m = 1;
        check("ovr_hold", {o_mem_req, o_mem_addr},
              {1'b1, pre_addr});
      end else begin
        drop_m = 0;
        check("ovr_issue", {o_mem_req, o_mem_addr},
              {1'b1, oval});
      end
    end else if (ack && drop_m) begin
      drop_m = 0;
      check("drop_issue", {o_mem_req, o_mem_addr},
            {1'b1, exp_pc});
    end else if (ack) begin
      check("fetch_addr", pre_addr, exp_pc);
      e.addr = pre_addr;
      e.word = i_mem_data;
      e.pred = is_pred(i_mem_data);
      q.push_back(e);
      acc_log.push_back(pre_addr);
      n_ack++;
      exp_pc = nxt(pre_addr, i_mem_data);
      check("fifo_cap", q.size() <= DEPTH, 1);
      if (q.size() < DEPTH)
        check("b2b", {o_mem_req, o_mem_addr},
              {1'b1, exp_pc});
      else
        check("full_stop", o_mem_req, 0);
    end else if (pre_req) begin
      check("req_hold", {o_mem_req, o_mem_addr},
            {1'b1, pre_addr});
    end

    if (!o_mem_req && q.size() < DEPTH) idle_run++;
    else idle_run = 0;
    if (idle_run > 2) begin
      check("starve", idle_run, 2);
      idle_run = 0;
    end
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic log_at(string tag, int idx,
                        logic [15:0] exp);
    if (acc_log.size() > idx)
      check(tag, acc_log[idx], exp);
    else
      check(tag, 17'h1_0000, exp);
  endtask

  initial begin
    int sz, a0, s0, j;
    bit found;
    jmp_en  = 0;
    lat_fix = 0;
    rdy_pct = 100;
    ovr_pct = 0;
    f_ovr   = 0;
    f_val   = '0;
    n_ack   = 0;
    n_sub   = 0;
    for (int a = 0; a < 16; a++)
      prog[16'(a)] = mk(0, 16'($urandom));
    prog[16'h0005] = mk(1, 16'h0040);
    prog[16'h0040] = mk(0, 16'($urandom));
    prog[16'h0041] = mk(3, 16'h0123);
    prog[16'hFFFE] = mk(0, 16'($urandom));
    prog[16'hFFFF] = mk(0, 16'($urandom));
    model_reset();

    #2 i_rst_n = 1'b0;
    #10;
    check("rst_req", o_mem_req, 0);
    check("rst_addr", o_mem_addr, 0);
    check("rst_sub", o_submit, 0);
    check("rst_out", {o_jmp_pred_pass, o_imm_pass, o_instr_l}, 0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // zero-wait streaming
    steps(2);
    n_ack = 0;
    n_sub = 0;
    steps(6);
    check("stream_acks", n_ack, 6);
    check("stream_subs", n_sub, 6);
    for (int i = 0; i < 4; i++)
      log_at("stream_addr", i, 16'(i));
    steps(8);
    j = -1;
    for (int i = 0; i < acc_log.size(); i++)
      if (j < 0 && acc_log[i] == 16'h0005) j = i;
    check("jmp_seen", j >= 0, 1);
    if (j >= 0) begin
      log_at("jmp_tgt", j + 1, 16'h0040);
      log_at("cond_jmp", j + 3, 16'h0042);
    end

    // decode stall then drain
    lat_fix = 2;
    rdy_pct = 0;
    a0 = n_ack;
    s0 = q.size();
    steps(10);
    check("stall_acks", n_ack - a0, DEPTH - s0);
    check("stall_full", q.size(), DEPTH);
    check("stall_noreq", o_mem_req, 0);
    rdy_pct = 100;
    lat_fix = 0;
    steps(10);

    // redirect while a slow request is pending
    lat_fix = 3;
    f_ovr = 1;
    f_val = 16'h0010;
    step();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (o_mem_req && o_mem_addr == 16'h0010 && !pend)
        found = 1;
      else
        step();
    end
    check("find_req10", found, 1);
    step();
    sz = acc_log.size();
    f_ovr = 1;
    f_val = 16'h0100;
    step();
    check("drop_addr", o_mem_addr, 16'h0010);
    steps(12);
    log_at("after_drop", sz, 16'h0100);

    // redirect coincident with ack, FIFO non-empty
    lat_fix = 0;
    rdy_pct = 0;
    f_ovr = 1;
    f_val = 16'h0200;
    step();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (q.size() == 1 && o_mem_req) found = 1;
      else step();
    end
    check("find_coinc", found, 1);
    rdy_pct = 100;
    f_ovr = 1;
    f_val = 16'h0300;
    step();
    check("coinc_nosub", o_submit, 0);
    check("coinc_addr", o_mem_addr, 16'h0300);
    sz = acc_log.size();
    steps(4);
    log_at("coinc_next", sz, 16'h0300);

    // PC wrap
    f_ovr = 1;
    f_val = 16'hFFFE;
    sz = acc_log.size();
    step();
    steps(7);
    log_at("wrap0", sz, 16'hFFFE);
    log_at("wrap1", sz + 1, 16'hFFFF);
    log_at("wrap2", sz + 2, 16'h0000);

    // async reset mid-request
    lat_fix = 3;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (o_mem_req) found = 1;
      else step();
    end
    check("find_req_rst", found, 1);
    step();
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_req", o_mem_req, 0);
    check("arst_sub", o_submit, 0);
    check("arst_out", {o_jmp_pred_pass, o_imm_pass, o_instr_l}, 0);
    model_reset();
    i_mem_ack = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    lat_fix = 0;
    sz = acc_log.size();
    steps(6);
    log_at("resume_pc", sz, 16'h0000);

    // randomized traffic
    jmp_en  = 1;
    lat_fix = -1;
    rdy_pct = 70;
    ovr_pct = 15;
    steps(3000);
    rdy_pct = 100;
    ovr_pct = 0;
    steps(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
